// File: rtl/ofs_fim_pcie_ss_tx_seg_arb.sv
// Round-robin, packet-locked arbiter merging NUM_REQ AXI-S segment streams
// into one registered TX stream; flags first beats that arrive without a header.
module ofs_fim_pcie_ss_tx_seg_arb #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 512,
    parameter int HDR_WIDTH   = 256,
    parameter int TUSER_WIDTH = HDR_WIDTH + 3
) (
    input  logic                               clk,
    input  logic                               rst_n,

    input  logic [NUM_REQ-1:0]                 in_tvalid,
    output logic [NUM_REQ-1:0]                 in_tready,
    input  logic [NUM_REQ-1:0]                 in_tlast,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]      in_tdata,
    input  logic [NUM_REQ*TUSER_WIDTH-1:0]     in_tuser,

    output logic                               out_tvalid,
    input  logic                               out_tready,
    output logic [DATA_WIDTH-1:0]              out_tdata,
    output logic [TUSER_WIDTH-1:0]             out_tuser,
    output logic                               out_tlast,
    output logic [$clog2(NUM_REQ)-1:0]         out_src,

    output logic                               err_sop
);

    localparam int SRC_W      = $clog2(NUM_REQ);
    localparam int HVALID_BIT = HDR_WIDTH;

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [SRC_W-1:0]   last_winner;
    logic [SRC_W-1:0]   owner;
    logic [SRC_W-1:0]   rr_idx;
    logic [SRC_W-1:0]   rr_grant;
    logic               rr_found;
    logic [SRC_W-1:0]   sel;

    logic               init_done;
    logic               out_can_accept;
    logic               accept;
    logic               first_beat;

    logic [DATA_WIDTH-1:0]  sel_data;
    logic [TUSER_WIDTH-1:0] sel_user;
    logic                   sel_last;

    // Round-robin search beginning one past the previous packet winner.
    // NOTE: every signal written in an always_comb gets a default first so no latch is inferred.
    always_comb begin
        rr_grant = '0;
        rr_found = 1'b0;
        rr_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            rr_idx = SRC_W'((int'(last_winner) + k) % NUM_REQ);
            if (!rr_found && in_tvalid[rr_idx]) begin
                rr_grant = rr_idx;
                rr_found = 1'b1;
            end
        end
    end

    assign sel            = (state == ST_LOCKED) ? owner : rr_grant;
    assign sel_data       = in_tdata[sel*DATA_WIDTH +: DATA_WIDTH];
    assign sel_user       = in_tuser[sel*TUSER_WIDTH +: TUSER_WIDTH];
    assign sel_last       = in_tlast[sel];

    // init_done keeps every ready low during the first cycle after reset release.
    assign out_can_accept = init_done && (!out_tvalid || out_tready);

    always_comb begin
        in_tready = '0;
        if (out_can_accept) begin
            if (state == ST_LOCKED) begin
                in_tready[owner] = 1'b1;
            end else if (rr_found) begin
                in_tready[rr_grant] = 1'b1;
            end
        end
    end

    assign accept     = in_tvalid[sel] && in_tready[sel];
    assign first_beat = accept && (state == ST_IDLE);

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (accept && !sel_last) state_next = ST_LOCKED;
            ST_LOCKED: if (accept && sel_last)  state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_done   <= 1'b0;
            last_winner <= SRC_W'(NUM_REQ - 1);
            owner       <= '0;
            err_sop     <= 1'b0;
        end else begin
            init_done <= 1'b1;
            if (first_beat) begin
                last_winner <= rr_grant;
                owner       <= rr_grant;
                if (!sel_user[HVALID_BIT]) begin
                    err_sop <= 1'b1;
                end
            end
        end
    end

    // NOTE: the output data register is reset too, since consumers rely on zero payload during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_tvalid <= 1'b0;
            out_tdata  <= '0;
            out_tuser  <= '0;
            out_tlast  <= 1'b0;
            out_src    <= '0;
        end else if (accept) begin
            out_tvalid <= 1'b1;
            out_tdata  <= sel_data;
            out_tuser  <= sel_user;
            out_tlast  <= sel_last;
            out_src    <= sel;
        end else if (out_tready) begin
            out_tvalid <= 1'b0;
        end
    end

    a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(in_tready));

    a_locked_owner_only: assert property (@(posedge clk) disable iff (!rst_n)
        (state == ST_LOCKED) |-> ((in_tready & ~(NUM_REQ'(1) << owner)) == '0));

    a_out_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (out_tvalid && !out_tready) |=> (out_tvalid && $stable(out_tdata) &&
        $stable(out_tuser) && $stable(out_tlast) && $stable(out_src)));

endmodule

// File: tb/tb_ofs_fim_pcie_ss_tx_seg_arb.sv
// Directed scoreboard bench for the TX segment arbiter: per-requester beat
// sources feed the DUT while a monitor pops expected beats off a queue.
module tb_ofs_fim_pcie_ss_tx_seg_arb;

    localparam int NR = 4;
    localparam int DW = 512;
    localparam int HW = 256;
    localparam int UW = HW + 3;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NR-1:0]       in_tvalid;
    logic [NR-1:0]       in_tready;
    logic [NR-1:0]       in_tlast;
    logic [NR*DW-1:0]    in_tdata;
    logic [NR*UW-1:0]    in_tuser;
    logic                out_tvalid;
    logic                out_tready;
    logic [DW-1:0]       out_tdata;
    logic [UW-1:0]       out_tuser;
    logic                out_tlast;
    logic [1:0]          out_src;
    logic                err_sop;

    always #5 clk = ~clk;

    ofs_fim_pcie_ss_tx_seg_arb #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .HDR_WIDTH(HW), .TUSER_WIDTH(UW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tlast(in_tlast),
        .in_tdata(in_tdata), .in_tuser(in_tuser),
        .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tdata(out_tdata),
        .out_tuser(out_tuser), .out_tlast(out_tlast), .out_src(out_src),
        .err_sop(err_sop)
    );

    typedef struct {
        int tid;
        int k;
        bit last;
        bit hv;
    } beat_t;

    typedef struct {
        logic [1:0]    src;
        logic [DW-1:0] data;
        logic [UW-1:0] user;
        logic          last;
    } exp_t;

    beat_t         src_mem [NR][8];
    int            s_cnt   [NR];
    int            s_head  [NR];
    bit            gate    [NR];
    exp_t          exp_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            n_pops   = 0;
    logic [NR-1:0] rdy_seen;
    logic [NR-1:0] acc;

    function automatic logic [DW-1:0] mk_data(int tid, int r, int k);
        logic [DW-1:0] d;
        for (int w = 0; w < DW/32; w++) d[w*32 +: 32] = {tid[7:0], r[7:0], k[7:0], w[7:0]};
        return d;
    endfunction

    function automatic logic [UW-1:0] mk_user(int tid, int r, int k, bit last, bit hv);
        logic [UW-1:0] u;
        logic [7:0]    t;
        t = tid[7:0] ^ 8'hA5;
        for (int w = 0; w < HW/32; w++) u[w*32 +: 32] = {t, r[7:0], k[7:0], w[7:0]};
        u[HW]   = hv;
        u[HW+1] = last;
        u[HW+2] = r[0];
        return u;
    endfunction

    task automatic check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic load(int r, int tid, int nbeats, bit hv0);
        for (int k = 0; k < nbeats; k++) begin
            src_mem[r][s_cnt[r]] = '{tid: tid, k: k, last: (k == nbeats - 1),
                                     hv: (k == 0) ? hv0 : 1'b0};
            s_cnt[r]++;
        end
    endtask

    task automatic expect_beat(int r, int tid, int k, bit last, bit hv);
        exp_t e;
        e.src  = r[1:0];
        e.data = mk_data(tid, r, k);
        e.user = mk_user(tid, r, k, last, hv);
        e.last = last;
        exp_q.push_back(e);
    endtask

    task automatic drive();
        beat_t b;
        for (int i = 0; i < NR; i++) begin
            if (gate[i] && s_head[i] < s_cnt[i]) begin
                b = src_mem[i][s_head[i]];
                in_tvalid[i]          = 1'b1;
                in_tlast[i]           = b.last;
                in_tdata[i*DW +: DW]  = mk_data(b.tid, i, b.k);
                in_tuser[i*UW +: UW]  = mk_user(b.tid, i, b.k, b.last, b.hv);
            end else begin
                in_tvalid[i] = 1'b0;
                in_tlast[i]  = 1'b0;
            end
        end
    endtask

    task automatic flush_sources();
        for (int i = 0; i < NR; i++) begin
            s_cnt[i]  = 0;
            s_head[i] = 0;
        end
    endtask

    // One clock: sample handshakes mid-cycle, then advance sources past the edge.
    task automatic step();
        @(negedge clk);
        rdy_seen = in_tready;
        acc      = in_tvalid & in_tready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) if (acc[i]) s_head[i]++;
        drive();
    endtask

    task automatic drain();
        for (int n = 0; n < 20 && exp_q.size() != 0; n++) step();
        check("scoreboard_drained", DW'(exp_q.size()), '0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && out_tvalid === 1'b1 && out_tready === 1'b1) begin
            n_pops++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected_beat: src %0d data %0h, required no beat", out_src, out_tdata);
            end else begin
                e = exp_q.pop_front();
                check("sb_src",  DW'(out_src),   DW'(e.src));
                check("sb_data", out_tdata,      e.data);
                check("sb_user", DW'(out_tuser), DW'(e.user));
                check("sb_last", DW'(out_tlast), DW'(e.last));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NR-1:0] grants1 [5];
        int            pops_before;
        grants1 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        rst_n      = 1'b0;
        out_tready = 1'b1;
        in_tvalid  = '0;
        in_tlast   = '0;
        in_tdata   = '0;
        in_tuser   = '0;
        for (int i = 0; i < NR; i++) gate[i] = 1'b1;
        flush_sources();

        // Round-robin over four single-beat packets, valids held through reset.
        load(0, 1, 1, 1'b1);
        load(0, 11, 1, 1'b1);
        load(1, 1, 1, 1'b1);
        load(2, 1, 1, 1'b1);
        load(3, 1, 1, 1'b1);
        expect_beat(0, 1, 0, 1'b1, 1'b1);
        expect_beat(1, 1, 0, 1'b1, 1'b1);
        expect_beat(2, 1, 0, 1'b1, 1'b1);
        expect_beat(3, 1, 0, 1'b1, 1'b1);
        expect_beat(0, 11, 0, 1'b1, 1'b1);
        drive();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_tvalid", DW'(out_tvalid), '0);
        check("rst_in_tready",  DW'(in_tready),  '0);
        check("rst_out_tlast",  DW'(out_tlast),  '0);
        check("rst_out_src",    DW'(out_src),    '0);
        check("rst_err_sop",    DW'(err_sop),    '0);
        check("rst_out_tdata",  out_tdata,       '0);
        check("rst_out_tuser",  DW'(out_tuser),  '0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        check("first_cycle_no_ready", DW'(rdy_seen), '0);
        for (int g = 0; g < 5; g++) begin
            step();
            check("rr_grant", DW'(rdy_seen), DW'(grants1[g]));
        end
        drain();

        // Three-beat packet from 2 stays contiguous while 0 waits.
        load(2, 2, 3, 1'b1);
        load(0, 2, 1, 1'b1);
        expect_beat(2, 2, 0, 1'b0, 1'b1);
        expect_beat(2, 2, 1, 1'b0, 1'b0);
        expect_beat(2, 2, 2, 1'b1, 1'b0);
        expect_beat(0, 2, 0, 1'b1, 1'b1);
        drive();
        step(); check("lock_grant_b0", DW'(rdy_seen), DW'(4'b0100));
        step(); check("lock_grant_b1", DW'(rdy_seen), DW'(4'b0100));
        step(); check("lock_grant_b2", DW'(rdy_seen), DW'(4'b0100));
        step(); check("after_lock_r0", DW'(rdy_seen), DW'(4'b0001));
        drain();
        check("no_err_midpkt_hvalid0", DW'(err_sop), '0);

        // Owner 1 stalls mid-packet; requester 3 must not be granted.
        load(1, 3, 3, 1'b1);
        load(3, 3, 1, 1'b1);
        expect_beat(1, 3, 0, 1'b0, 1'b1);
        expect_beat(1, 3, 1, 1'b0, 1'b0);
        expect_beat(1, 3, 2, 1'b1, 1'b0);
        expect_beat(3, 3, 0, 1'b1, 1'b1);
        drive();
        step(); check("stall_grant_b0", DW'(rdy_seen), DW'(4'b0010));
        gate[1] = 1'b0;
        drive();
        pops_before = n_pops;
        for (int c = 0; c < 5; c++) begin
            step();
            check("stall_non_owner_ready", DW'(rdy_seen & 4'b1101), '0);
        end
        check("stall_out_beats", DW'(n_pops - pops_before), DW'(1));
        gate[1] = 1'b1;
        drive();
        step(); check("resume_b1", DW'(rdy_seen), DW'(4'b0010));
        step(); check("resume_b2", DW'(rdy_seen), DW'(4'b0010));
        step(); check("then_r3",   DW'(rdy_seen), DW'(4'b1000));
        drain();

        // Output back-pressure with the register full.
        load(0, 4, 4, 1'b1);
        for (int k = 0; k < 4; k++) expect_beat(0, 4, k, (k == 3), (k == 0));
        drive();
        step(); check("bp_grant_b0", DW'(rdy_seen), DW'(4'b0001));
        out_tready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            check("bp_no_ready",   DW'(rdy_seen),   '0);
            check("bp_hold_valid", DW'(out_tvalid), DW'(1));
            check("bp_hold_data",  out_tdata,       mk_data(4, 0, 0));
            check("bp_hold_user",  DW'(out_tuser),  DW'(mk_user(4, 0, 0, 1'b0, 1'b1)));
            check("bp_hold_last",  DW'(out_tlast),  '0);
            check("bp_hold_src",   DW'(out_src),    '0);
        end
        out_tready = 1'b1;
        for (int c = 1; c < 4; c++) begin
            step();
            check("bp_resume_rate", DW'(rdy_seen), DW'(4'b0001));
        end
        drain();

        // Headerless first beat from requester 3.
        check("err_sop_clear_before", DW'(err_sop), '0);
        load(3, 5, 1, 1'b0);
        expect_beat(3, 5, 0, 1'b1, 1'b0);
        drive();
        step(); check("nohdr_grant", DW'(rdy_seen), DW'(4'b1000));
        check("err_sop_set", DW'(err_sop), DW'(1));
        drain();
        repeat (3) step();
        check("err_sop_sticky", DW'(err_sop), DW'(1));

        // Reset during beat 2 of a 4-beat packet.
        load(1, 6, 4, 1'b1);
        expect_beat(1, 6, 0, 1'b0, 1'b1);
        drive();
        step(); check("mid_rst_b0", DW'(rdy_seen), DW'(4'b0010));
        step(); check("mid_rst_b1", DW'(rdy_seen), DW'(4'b0010));
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_tvalid", DW'(out_tvalid), '0);
        check("mid_rst_in_tready",  DW'(in_tready),  '0);
        check("mid_rst_err_sop",    DW'(err_sop),    '0);
        flush_sources();
        load(0, 7, 1, 1'b1);
        load(1, 7, 1, 1'b1);
        load(2, 7, 1, 1'b1);
        load(3, 7, 1, 1'b1);
        expect_beat(0, 7, 0, 1'b1, 1'b1);
        expect_beat(1, 7, 0, 1'b1, 1'b1);
        expect_beat(2, 7, 0, 1'b1, 1'b1);
        expect_beat(3, 7, 0, 1'b1, 1'b1);
        drive();
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        check("post_rst_no_ready", DW'(rdy_seen), '0);
        for (int g = 0; g < 4; g++) begin
            step();
            check("post_rst_grant", DW'(rdy_seen), DW'(grants1[g]));
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
